// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio, default baud divisor.
// The receive state encoding matches the transmit block so both can be debugged the same way.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;

  // 50 MHz / 115200 baud / 16 ticks per bit
  localparam int CLKS_PER_SAMPLE_DEF = 27;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: counts clk cycles while enabled and pulses tick once per sample period.
// The count is held at zero while disabled, so every frame starts from a clean phase.
module uart_sample_tick #(
  parameter int CLKS_PER_SAMPLE = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SAMPLE - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver with 16x oversampling and 3-sample majority vote at mid-bit.
// Emits a one-cycle valid pulse per good byte and a frame_err pulse per bad stop bit.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_DEF,
  parameter int OVERSAMPLE      = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMP_A    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMP_B    = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] SAMP_C    = 4'(OVERSAMPLE / 2 + 1);

  rx_state_e  state, next_state;
  logic       rx_meta, rx_s;
  logic       armed;
  logic       tick;
  logic [3:0] samp_idx;
  logic [2:0] bit_idx;
  logic       samp_a, samp_b, samp_c;
  logic       bit_val;
  logic [7:0] shift_reg;
  logic       valid_d, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_sample_tick #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state != RX_IDLE),
    .tick(tick)
  );

  // The stop bit is decided on its last sample tick, so the live line stands in for the third sample.
  assign bit_val = majority3(samp_a, samp_b, (samp_idx == SAMP_C) ? rx_s : samp_c);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    next_state  = state;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state)
      RX_IDLE: begin
        if (armed && !rx_s) next_state = RX_START;
      end
      RX_START: begin
        if (tick && samp_idx == SAMP_LAST) next_state = bit_val ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (tick && samp_idx == SAMP_LAST && bit_idx == 3'd7) next_state = RX_STOP;
      end
      RX_STOP: begin
        if (tick && samp_idx == SAMP_C) begin
          next_state  = RX_IDLE;
          valid_d     = bit_val;
          frame_err_d = !bit_val;
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  // Only a high line re-arms start detection, so a held break cannot retrigger frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (state == RX_IDLE) begin
      if (next_state == RX_START) armed <= 1'b0;
      else if (rx_s)              armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == RX_IDLE) begin
      samp_idx <= '0;
    end else if (tick) begin
      samp_idx <= samp_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
      samp_c <= 1'b1;
    end else if (tick) begin
      if (samp_idx == SAMP_A) samp_a <= rx_s;
      if (samp_idx == SAMP_B) samp_b <= rx_s;
      if (samp_idx == SAMP_C) samp_c <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (state == RX_START && next_state == RX_DATA) begin
      bit_idx <= '0;
    end else if (state == RX_DATA && tick && samp_idx == SAMP_LAST) begin
      shift_reg <= {bit_val, shift_reg[7:1]};
      bit_idx   <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= valid_d;
      frame_err <= frame_err_d;
      if (valid_d) out <= shift_reg;
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the UART receiver: nominal, back-to-back, glitch, framing error, reset, baud skew.
// A negedge monitor counts pulses and timestamps busy/valid edges for latency checks.
module tb_receiver;

  localparam int CLKS = 4;
  localparam int BIT  = 16 * CLKS;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_busy_rise = 0;
  int t_valid = 0, t_busy_rise = 0, t_fall = 0;
  int low_run = 0, last_gap = 0;
  logic [7:0] last_out = 8'h00;
  logic busy_q = 1'b0;
  logic both_seen = 1'b0;

  int v0, f0, b0;

  receiver #(
    .CLKS_PER_SAMPLE(CLKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .out      (out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid  <= n_valid + 1;
      last_out <= out;
      t_valid  <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (valid && frame_err) both_seen <= 1'b1;
    if (busy && !busy_q) begin
      n_busy_rise <= n_busy_rise + 1;
      t_busy_rise <= cyc;
      last_gap    <= low_run;
    end
    low_run <= busy ? 0 : low_run + 1;
    busy_q  <= busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; when abort_bit >= 0, rst is raised mid-way through that data bit
  // and held until the stop bit so the abandoned frame leaves no trace.
  task automatic send_frame(input logic [7:0] data, input int bit_clks, input logic stop_bit,
                            input int abort_bit);
    logic [9:0] bits;
    bits   = {stop_bit, data, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        wait_cycles(bit_clks / 2);
        rst = 1'b1;
        wait_cycles(2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_ferr", 32'(frame_err), 32'd0);
        check("abort_out", 32'(out), 32'h00);
        wait_cycles(bit_clks - bit_clks / 2 - 2);
      end else if (abort_bit >= 0 && i == 9) begin
        rst = 1'b0;
        wait_cycles(bit_clks);
      end else begin
        wait_cycles(bit_clks);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(1);
    check("rst_out", 32'(out), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wait_cycles(10);

    // Nominal 0xA5
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, BIT, 1'b1, -1);
    wait_cycles(BIT);
    check("nom_cnt", 32'(n_valid - v0), 32'd1);
    check("nom_out", 32'(last_out), 32'hA5);
    check("nom_ferr", 32'(n_ferr - f0), 32'd0);
    check("nom_latency", 32'(t_valid - t_busy_rise), 32'(154 * CLKS));
    check("nom_sync", 32'(t_busy_rise - t_fall), 32'd3);

    // Back-to-back 0x00 then 0xFF
    v0 = n_valid;
    send_frame(8'h00, BIT, 1'b1, -1);
    check("b2b_out0", 32'(last_out), 32'h00);
    send_frame(8'hFF, BIT, 1'b1, -1);
    wait_cycles(BIT);
    check("b2b_out1", 32'(last_out), 32'hFF);
    check("b2b_cnt", 32'(n_valid - v0), 32'd2);
    check("b2b_gap", 32'(last_gap >= 1 && last_gap <= 8 * CLKS), 32'd1);

    // Glitch: low for 4 sample ticks
    v0 = n_valid; f0 = n_ferr; b0 = n_busy_rise;
    rx = 1'b0;
    wait_cycles(4 * CLKS);
    rx = 1'b1;
    wait_cycles(200);
    check("glitch_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
    check("glitch_busy_rises", 32'(n_busy_rise - b0), 32'd1);
    check("glitch_busy_end", 32'(busy), 32'd0);

    // Framing error then a two-frame break
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, BIT, 1'b0, -1);
    wait_cycles(20 * BIT);
    check("ferr_cnt", 32'(n_ferr - f0), 32'd1);
    check("ferr_valid", 32'(n_valid - v0), 32'd0);
    check("ferr_out_held", 32'(out), 32'hFF);
    rx = 1'b1;
    wait_cycles(200);
    check("break_ferr", 32'(n_ferr - f0), 32'd1);
    check("break_valid", 32'(n_valid - v0), 32'd0);

    // Reset during data bit 4 of 0x81, then 0x42
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, BIT, 1'b1, 4);
    wait_cycles(BIT);
    check("abort_no_pulse", 32'(n_valid - v0 + n_ferr - f0), 32'd0);
    send_frame(8'h42, BIT, 1'b1, -1);
    wait_cycles(BIT);
    check("post_rst_cnt", 32'(n_valid - v0), 32'd1);
    check("post_rst_out", 32'(last_out), 32'h42);

    // Baud skew +3% / -3%
    v0 = n_valid;
    send_frame(8'h3C, 66, 1'b1, -1);
    wait_cycles(BIT);
    check("slow_out", 32'(last_out), 32'h3C);
    check("slow_cnt", 32'(n_valid - v0), 32'd1);
    send_frame(8'h3C, 62, 1'b1, -1);
    wait_cycles(BIT);
    check("fast_out", 32'(last_out), 32'h3C);
    check("fast_cnt", 32'(n_valid - v0), 32'd2);

    check("valid_ferr_overlap", 32'(both_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

UART receive path, the counterpart of the UART transmit block. It recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit, idle-high line) from the asynchronous `rx` pin using 16x oversampling and 3-sample majority voting. Each good byte is presented as a one-cycle `valid` pulse, and each bad stop bit as a `frame_err` pulse. It sits between the board pin and the byte consumer, for example a command decoder.

## Interface
- `CLKS_PER_SAMPLE`, default 27: `clk` cycles per oversample tick (50 MHz / 115200 / 16). Must be ≥ 2.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; other values are unsupported.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial line, idle high.
- `out`  out  8  last correctly received byte; holds its value until the next good frame.
- `valid`  out  1  one-cycle pulse; `out` is updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Tick counter:
  - Width is $clog2(CLKS_PER_SAMPLE).
  - Held at 0 in IDLE.
  - Otherwise counts 0..CLKS_PER_SAMPLE-1 and wraps; `tick` = (count == CLKS_PER_SAMPLE-1).
- Sample index: 4 bits, advances on each `tick`, wraps 15→0. Bit index: 3 bits.
- Each bit spans sample indices 0..15. `rx_s` is captured at indices 7, 8 and 9, and the bit value is the majority of the three.
- IDLE:
  - `armed` is set whenever `rx_s`=1.
  - If `armed` and `rx_s`=0, go to START. On entry, clear the sample index, tick counter and `armed`.
- START: on the tick at index 15, evaluate the majority.
  - 1 (false start or glitch): go to IDLE with no output pulse.
  - 0: go to DATA with bit index 0.
- DATA:
  - On each tick at index 15, shift the majority bit in at the MSB of the shift register (LSB arrives first).
  - After bit index 7, go to STOP.
- STOP: on the tick at index 9, evaluate the majority and go to IDLE.
  - 1: `out` ← shift register and `valid`=1.
  - 0: `frame_err`=1 and `out` unchanged.
- Leaving STOP at mid-bit leaves half a bit of margin for back-to-back frames.
- A line held low (break) after a framing error produces no further frames until `rx_s` returns high, which re-sets `armed`.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `out`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, `armed`=0, synchronizer=1.
- `rst` mid-frame aborts immediately in the next cycle with no pulse. Reset has priority over every other event.
- Pin falling edge to START entry: 3 `clk` cycles (2 synchronizer cycles plus 1 state register cycle).
- START entry to the `valid`/`frame_err` pulse: exactly 154 × CLKS_PER_SAMPLE `clk` cycles, i.e. 16 + 8×16 + 10 ticks. The pulse is registered on the cycle after the 154th tick.
- `busy` rises on START entry and falls in the same cycle as the `valid`/`frame_err` pulse, or one cycle after a false-start decision.
- Tolerates at least ±3% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - state encodings RX_IDLE/RX_START/RX_DATA/RX_STOP, 2 bits, matching the transmit encoding;
  - `OVERSAMPLE`;
  - the default CLKS_PER_SAMPLE constant.
- One sub-module, `uart_sample_tick`: a resettable, enable-gated counter producing `tick` (counter held at 0 while the enable is low). The synchronizer, majority voter, shift register and FSM stay inline.

## Test plan
- Nominal byte: 0xA5 sent at the nominal bit time → one `valid` pulse with `out`=0xA5, exactly 154×CLKS_PER_SAMPLE cycles after START entry; `frame_err` stays 0.
- Back-to-back: 0x00 then 0xFF with no idle gap → two `valid` pulses with `out`=0x00 then 0xFF; `busy` drops for ≤ 8 ticks between the frames.
- Glitch: `rx` low for 4 sample ticks, then high → no `valid`, no `frame_err`; `busy` pulses once, then returns to 0.
- Framing error: 0x3C with stop bit 0, line then held low for 2 frames → exactly one `frame_err` pulse, `out` keeps its previous value, no further pulses until the line goes high.
- Reset mid-frame: assert `rst` during data bit 4 of 0x81, then send 0x42 → no pulse for the aborted frame, all outputs at reset values, then `valid` with `out`=0x42.
- Baud skew: 0x3C sent at +3% and −3% bit time → `valid` with `out`=0x3C in both cases.
